// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared FPU command encodings and arbiter defaults
package riscv_defines;

    localparam int C_CMD    = 4;
    localparam int C_RM     = 3;
    localparam int C_FFLAG  = 5;

    localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
    localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
    localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
    localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
    localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
    localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
    localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
    localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
    localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
    localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
    localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
    localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

    localparam int C_NB_REQ_DEF          = 2;
    localparam int C_MAX_OUTSTANDING_DEF = 4;

endpackage

// File: rtl/riscv_fpu_tag_fifo.sv
// rtl/riscv_fpu_tag_fifo.sv - in-order requester tag FIFO for outstanding FPU ops
module riscv_fpu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/riscv_fpu_arbiter.sv
// rtl/riscv_fpu_arbiter.sv - round-robin sharing of one FPU with in-order result routing
module riscv_fpu_arbiter
    import riscv_defines::*;
#(
    parameter int NB_REQ          = C_NB_REQ_DEF,
    parameter int MAX_OUTSTANDING = C_MAX_OUTSTANDING_DEF
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NB_REQ-1:0]               req_i,
    output logic [NB_REQ-1:0]               gnt_o,
    input  logic [NB_REQ-1:0][C_CMD-1:0]    op_i,
    input  logic [NB_REQ-1:0][C_RM-1:0]     rm_i,
    input  logic [NB_REQ-1:0][31:0]         operand_a_i,
    input  logic [NB_REQ-1:0][31:0]         operand_b_i,
    input  logic [NB_REQ-1:0][31:0]         operand_c_i,
    output logic                            fpu_req_o,
    input  logic                            fpu_gnt_i,
    output logic [C_CMD-1:0]                fpu_op_o,
    output logic [C_RM-1:0]                 fpu_rm_o,
    output logic [31:0]                     fpu_a_o,
    output logic [31:0]                     fpu_b_o,
    output logic [31:0]                     fpu_c_o,
    input  logic                            fpu_rvalid_i,
    input  logic [31:0]                     fpu_result_i,
    input  logic [C_FFLAG-1:0]              fpu_flags_i,
    output logic [NB_REQ-1:0]               rvalid_o,
    output logic [31:0]                     result_o,
    output logic [C_FFLAG-1:0]              flags_o,
    output logic                            err_o
);

    localparam int TAG_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    logic [TAG_W-1:0] rr_q;
    logic [TAG_W-1:0] win_idx;
    logic [TAG_W-1:0] cand;
    logic [TAG_W-1:0] head_tag;
    logic             win_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             handshake;
    logic             pop;
    logic             err_q;

    // Scan upward from the round-robin pointer, wrapping at NB_REQ.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (int'(rr_q) + i >= NB_REQ) cand = TAG_W'(int'(rr_q) + i - NB_REQ);
            else                          cand = TAG_W'(int'(rr_q) + i);
            if (!win_valid && req_i[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign fpu_req_o = win_valid && !fifo_full;
    assign handshake = fpu_gnt_i && fpu_req_o;
    assign pop       = fpu_rvalid_i && !fifo_empty;

    always_comb begin
        fpu_op_o = C_FPU_NOP_CMD;
        fpu_rm_o = '0;
        fpu_a_o  = '0;
        fpu_b_o  = '0;
        fpu_c_o  = '0;
        if (win_valid) begin
            fpu_op_o = op_i[win_idx];
            fpu_rm_o = rm_i[win_idx];
            fpu_a_o  = operand_a_i[win_idx];
            fpu_b_o  = operand_b_i[win_idx];
            fpu_c_o  = operand_c_i[win_idx];
        end
    end

    always_comb begin
        gnt_o = '0;
        if (handshake) gnt_o[win_idx] = 1'b1;
    end

    always_comb begin
        rvalid_o = '0;
        if (pop) rvalid_o[head_tag] = 1'b1;
    end

    assign result_o = fpu_result_i;
    assign flags_o  = fpu_flags_i;
    assign err_o    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (handshake) begin
                rr_q <= (win_idx == TAG_W'(NB_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            // A result with nothing outstanding is a protocol violation by the FPU.
            err_q <= fpu_rvalid_i && fifo_empty;
        end
    end

    riscv_fpu_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (handshake),
        .push_data (win_idx),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_tag)
    );

endmodule

// File: tb/tb_riscv_fpu_arbiter.sv
// tb/tb_riscv_fpu_arbiter.sv - self-checking bench for riscv_fpu_arbiter
module tb_riscv_fpu_arbiter;
    import riscv_defines::*;

    localparam int NB   = 2;
    localparam int MAXO = 4;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NB-1:0]              req = '0;
    logic [NB-1:0]              gnt_o;
    logic [NB-1:0][C_CMD-1:0]   op = '0;
    logic [NB-1:0][C_RM-1:0]    rm = '0;
    logic [NB-1:0][31:0]        opa = '0;
    logic [NB-1:0][31:0]        opb = '0;
    logic [NB-1:0][31:0]        opc = '0;
    logic                       fpu_req_o;
    logic                       fpu_gnt = 1'b0;
    logic [C_CMD-1:0]           fpu_op_o;
    logic [C_RM-1:0]            fpu_rm_o;
    logic [31:0]                fpu_a_o, fpu_b_o, fpu_c_o;
    logic                       fpu_rvalid = 1'b0;
    logic [31:0]                fpu_result = '0;
    logic [C_FFLAG-1:0]         fpu_flags = '0;
    logic [NB-1:0]              rvalid_o;
    logic [31:0]                result_o;
    logic [C_FFLAG-1:0]         flags_o;
    logic                       err_o;

    int checks = 0;
    int errors = 0;
    int q[$];
    int rr = 0;
    bit err_pend = 1'b0;

    always #5 clk = ~clk;

    riscv_fpu_arbiter #(.NB_REQ(NB), .MAX_OUTSTANDING(MAXO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req),
        .gnt_o        (gnt_o),
        .op_i         (op),
        .rm_i         (rm),
        .operand_a_i  (opa),
        .operand_b_i  (opb),
        .operand_c_i  (opc),
        .fpu_req_o    (fpu_req_o),
        .fpu_gnt_i    (fpu_gnt),
        .fpu_op_o     (fpu_op_o),
        .fpu_rm_o     (fpu_rm_o),
        .fpu_a_o      (fpu_a_o),
        .fpu_b_o      (fpu_b_o),
        .fpu_c_o      (fpu_c_o),
        .fpu_rvalid_i (fpu_rvalid),
        .fpu_result_i (fpu_result),
        .fpu_flags_i  (fpu_flags),
        .rvalid_o     (rvalid_o),
        .result_o     (result_o),
        .flags_o      (flags_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic randomize_fields(input logic [31:0] res);
        for (int k = 0; k < NB; k++) begin
            op[k]  = C_CMD'($urandom_range(0, 11));
            rm[k]  = C_RM'($urandom_range(0, 4));
            opa[k] = $urandom;
            opb[k] = $urandom;
            opc[k] = $urandom;
        end
        fpu_result = res;
        fpu_flags  = C_FFLAG'($urandom_range(0, 31));
    endtask

    // One clock of stimulus; the model tracks outstanding owners as a queue of indices.
    task automatic step(input logic [1:0] r, input logic g, input logic rv, input logic [31:0] res);
        logic [1:0] one;
        logic [1:0] gexp;
        logic [1:0] rvexp;
        int  w;
        bit  any;
        bit  freq;
        bit  was_empty;
        one = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        req = r;
        fpu_gnt = g;
        fpu_rvalid = rv;
        randomize_fields(res);
        #2;
        any  = (r != 2'b00);
        freq = any && (q.size() < MAXO);
        w = 0;
        for (int i = 0; i < NB; i++) begin
            if (r[(rr + i) % NB] && !(i > 0 && r[(rr + i - 1) % NB]) && (i == 0 || !r[rr % NB])) begin
                w = (rr + i) % NB;
                break;
            end
        end
        if (any && !r[w]) begin
            for (int i = 0; i < NB; i++) if (r[(rr + i) % NB]) begin w = (rr + i) % NB; break; end
        end
        gexp  = (g && freq) ? (one << w) : 2'b00;
        was_empty = (q.size() == 0);
        rvexp = (rv && !was_empty) ? (one << q[0]) : 2'b00;
        chk("fpu_req", 32'(fpu_req_o), 32'(freq));
        chk("gnt", 32'(gnt_o), 32'(gexp));
        chk("fpu_op", 32'(fpu_op_o), any ? 32'(op[w]) : 32'(C_FPU_NOP_CMD));
        chk("fpu_rm", 32'(fpu_rm_o), any ? 32'(rm[w]) : 32'd0);
        chk("fpu_a", fpu_a_o, any ? opa[w] : 32'd0);
        chk("fpu_b", fpu_b_o, any ? opb[w] : 32'd0);
        chk("fpu_c", fpu_c_o, any ? opc[w] : 32'd0);
        chk("rvalid", 32'(rvalid_o), 32'(rvexp));
        chk("result", result_o, res);
        chk("flags", 32'(flags_o), 32'(fpu_flags));
        chk("err", 32'(err_o), 32'(err_pend));
        if (rv && !was_empty) void'(q.pop_front());
        if (gexp != 2'b00) begin
            q.push_back(w);
            rr = (w + 1) % NB;
        end
        err_pend = rv && was_empty;
    endtask

    // One clock with reset held low; combinational grants still follow the reset state.
    task automatic reset_cycle(input logic [1:0] r);
        logic [1:0] gexp;
        @(negedge clk);
        rst_n = 1'b0;
        req = r;
        fpu_gnt = 1'b1;
        fpu_rvalid = 1'b0;
        randomize_fields($urandom);
        #2;
        gexp = r[0] ? 2'b01 : (r[1] ? 2'b10 : 2'b00);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_fpu_req", 32'(fpu_req_o), 32'(r != 2'b00));
        chk("rst_gnt", 32'(gnt_o), 32'(gexp));
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        q.delete();
        rr = 0;
        err_pend = 1'b0;
    endtask

    initial begin
        reset_cycle(2'b00);
        reset_cycle(2'b10);

        repeat (4) step(2'b11, 1'b1, 1'b0, 32'h0);
        step(2'b11, 1'b1, 1'b0, 32'h0);

        step(2'b01, 1'b1, 1'b1, 32'h3F800000);
        step(2'b01, 1'b1, 1'b0, 32'h0);

        repeat (4) step(2'b00, 1'b0, 1'b1, 32'h3F800000);

        step(2'b00, 1'b0, 1'b1, 32'h40000000);
        step(2'b00, 1'b0, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);

        repeat (3) step(2'b10, 1'b0, 1'b0, 32'h0);
        step(2'b10, 1'b1, 1'b0, 32'h0);

        step(2'b11, 1'b1, 1'b0, 32'h0);
        reset_cycle(2'b00);
        step(2'b00, 1'b0, 1'b1, 32'h12345678);
        step(2'b11, 1'b1, 1'b0, 32'h0);
        step(2'b00, 1'b0, 1'b0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) reset_cycle(2'($urandom_range(0, 3)));
            else step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom);
        end
        step(2'b00, 1'b0, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
